set_assoc_btb: RTL and testbench

SET_ASSOC_BTB -- requirements
Module: set_assoc_btb

---
 rtl/riscv_defines.sv | 25 ++
 rtl/btb_clear_fsm.sv | 53 +++++
 rtl/set_assoc_btb.sv | 153 +++++++++++++++
 tb/tb_set_assoc_btb.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
// riscv_defines: shared BTB entry layout, defaults
// and clear-sweep state encoding.
package riscv_defines;

  localparam int BTB_WAYS      = 2;
  localparam int BTB_SETS      = 16;
  localparam int BTB_CTR_WIDTH = 2;

  // Widest tag (SETS = 2) and widest counter supported.
  localparam int BTB_TAG_MAXW  = 29;
  localparam int BTB_CTR_MAXW  = 8;

  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_MAXW-1:0] tag;
    logic [31:0]             target;
    logic [BTB_CTR_MAXW-1:0] ctr;
  } btb_way_t;

  typedef enum logic {
    IDLE,
    CLEAR
  } btb_clr_state_e;

endpackage

// File: rtl/btb_clear_fsm.sv
// btb_clear_fsm: walks every set once after reset
// or flush so the BTB can invalidate it.
module btb_clear_fsm
  import riscv_defines::*;
#(
  parameter int SETS = BTB_SETS,
  localparam int IW  = $clog2(SETS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  output logic          busy_o,
  output logic [IW-1:0] clr_idx_o
);

  localparam logic [IW-1:0] LAST = IW'(SETS - 1);

  btb_clr_state_e state_q;
  logic [IW-1:0]  clr_idx_q;
  logic           busy_q;

  // Sweep one set per cycle; rst or flush restarts at set 0.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      state_q   <= CLEAR;
      clr_idx_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
        end
        CLEAR: begin
          if (clr_idx_q == LAST) begin
            state_q   <= IDLE;
            clr_idx_q <= '0;
            busy_q    <= 1'b0;
          end else begin
            clr_idx_q <= clr_idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign clr_idx_o = clr_idx_q;

endmodule

// File: rtl/set_assoc_btb.sv
// set_assoc_btb: set-associative branch target buffer
// with saturating direction counters and RR victims.
module set_assoc_btb
  import riscv_defines::*;
#(
  parameter int WAYS      = BTB_WAYS,
  parameter int SETS      = BTB_SETS,
  parameter int CTR_WIDTH = BTB_CTR_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] pc_f,
  output logic        btb_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic [31:0] pc_e,
  input  logic        cflow_valid,
  input  logic        cflow_taken,
  input  logic [31:0] cflow_target,
  output logic        busy
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;
  localparam int PW = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CW = BTB_CTR_MAXW;
  localparam int GW = BTB_TAG_MAXW;

  localparam logic [CW-1:0] CMAX =
    CW'((1 << CTR_WIDTH) - 1);
  localparam logic [CW-1:0] CWEAK =
    CW'(1 << (CTR_WIDTH - 1));
  localparam logic [PW-1:0] PLAST = PW'(WAYS - 1);

  btb_way_t      mem_q [WAYS][SETS];
  logic [PW-1:0] rr_q  [SETS];

  logic [IW-1:0] clr_idx;
  logic [IW-1:0] idx_f;
  logic [IW-1:0] idx_e;
  logic [GW-1:0] tag_f;
  logic [GW-1:0] tag_e;

  logic          hit_f;
  logic [PW-1:0] way_f;
  logic          hit_e;
  logic [PW-1:0] way_e;
  logic          inv_e;
  logic [PW-1:0] inv_way;
  logic [PW-1:0] vic_way;
  logic [PW-1:0] rr_d;
  logic [CW-1:0] ctr_q;
  logic [CW-1:0] ctr_d;
  logic          upd_en;

  btb_clear_fsm #(
    .SETS (SETS)
  ) u_clr (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush),
    .busy_o    (busy),
    .clr_idx_o (clr_idx)
  );

  assign idx_f = pc_f[2 +: IW];
  assign idx_e = pc_e[2 +: IW];
  assign tag_f = GW'(pc_f[31 -: TW]);
  assign tag_e = GW'(pc_e[31 -: TW]);

  // Fetch-side tag match; tags are unique per set.
  always_comb begin
    hit_f = 1'b0;
    way_f = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (mem_q[w][idx_f].valid &&
          mem_q[w][idx_f].tag == tag_f) begin
        hit_f = 1'b1;
        way_f = PW'(w);
      end
    end
  end

  assign btb_hit     = hit_f & ~busy;
  assign pred_taken  = btb_hit &
    mem_q[way_f][idx_f].ctr[CTR_WIDTH-1];
  assign pred_target = btb_hit ?
    mem_q[way_f][idx_f].target : 32'h0;

  // Update-side match and lowest-index free way.
  always_comb begin
    hit_e   = 1'b0;
    way_e   = '0;
    inv_e   = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (mem_q[w][idx_e].valid &&
          mem_q[w][idx_e].tag == tag_e) begin
        hit_e = 1'b1;
        way_e = PW'(w);
      end
      if (!mem_q[w][idx_e].valid) begin
        inv_e   = 1'b1;
        inv_way = PW'(w);
      end
    end
  end

  assign vic_way = inv_e ? inv_way : rr_q[idx_e];
  assign rr_d    = (rr_q[idx_e] == PLAST) ?
    '0 : rr_q[idx_e] + 1'b1;

  // Saturating counter step for the hit way.
  always_comb begin
    ctr_q = mem_q[way_e][idx_e].ctr;
    ctr_d = ctr_q;
    if (cflow_taken) begin
      if (ctr_q != CMAX) ctr_d = ctr_q + 1'b1;
    end else begin
      if (ctr_q != '0) ctr_d = ctr_q - 1'b1;
    end
  end

  assign upd_en = cflow_valid & ~busy &
                  ~rst & ~flush;

  // Entry storage: sweep clear, else train or allocate.
  always_ff @(posedge clk) begin
    if (busy) begin
      for (int w = 0; w < WAYS; w++) begin
        mem_q[w][clr_idx] <= '0;
      end
      rr_q[clr_idx] <= '0;
    end else if (upd_en) begin
      if (hit_e) begin
        mem_q[way_e][idx_e].ctr <= ctr_d;
        if (cflow_taken) begin
          mem_q[way_e][idx_e].target <= cflow_target;
        end
      end else if (cflow_taken) begin
        mem_q[vic_way][idx_e] <= '{
          valid:  1'b1,
          tag:    tag_e,
          target: cflow_target,
          ctr:    CWEAK
        };
        if (!inv_e) rr_q[idx_e] <= rr_d;
      end
    end
  end

endmodule

// File: tb/tb_set_assoc_btb.sv
// tb_set_assoc_btb: directed table, flush sequence
// and random traffic against a behavioural model.
module tb_set_assoc_btb;

  localparam int SETS = 16;
  localparam int WAYS = 2;
  localparam int NRND = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] pc_f;
  logic        btb_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] pc_e;
  logic        cflow_valid;
  logic        cflow_taken;
  logic [31:0] cflow_target;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  set_assoc_btb dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .pc_f         (pc_f),
    .btb_hit      (btb_hit),
    .pred_taken   (pred_taken),
    .pred_target  (pred_target),
    .pc_e         (pc_e),
    .cflow_valid  (cflow_valid),
    .cflow_taken  (cflow_taken),
    .cflow_target (cflow_target),
    .busy         (busy)
  );

  // Reference: per-set list of entries.
  typedef struct {
    bit          v;
    int unsigned tag;
    logic [31:0] tgt;
    int          ctr;
  } ment_t;

  ment_t m [SETS][WAYS];
  int    m_rr [SETS];
  int    m_busy = 0;

  function automatic int set_of(logic [31:0] pc);
    return int'((pc / 4) % SETS);
  endfunction

  function automatic int unsigned tag_of(
    logic [31:0] pc);
    return pc / (4 * SETS);
  endfunction

  task automatic m_lookup(
    input  logic [31:0] pc,
    output bit          hit,
    output bit          tk,
    output logic [31:0] tg);
    int s;
    s   = set_of(pc);
    hit = 0;
    tk  = 0;
    tg  = 32'h0;
    if (m_busy == 0) begin
      for (int w = 0; w < WAYS; w++) begin
        if (m[s][w].v && m[s][w].tag == tag_of(pc)) begin
          hit = 1;
          tk  = (m[s][w].ctr >= 2);
          tg  = m[s][w].tgt;
        end
      end
    end
  endtask

  task automatic m_train(
    input logic [31:0] pc,
    input bit          tk,
    input logic [31:0] tg);
    int s;
    int hw;
    int vw;
    s  = set_of(pc);
    hw = -1;
    for (int w = 0; w < WAYS; w++) begin
      if (m[s][w].v && m[s][w].tag == tag_of(pc))
        hw = w;
    end
    if (hw >= 0) begin
      if (tk) begin
        if (m[s][hw].ctr < 3) m[s][hw].ctr++;
        m[s][hw].tgt = tg;
      end else if (m[s][hw].ctr > 0) begin
        m[s][hw].ctr--;
      end
    end else if (tk) begin
      vw = -1;
      for (int w = WAYS - 1; w >= 0; w--) begin
        if (!m[s][w].v) vw = w;
      end
      if (vw < 0) begin
        vw      = m_rr[s];
        m_rr[s] = (m_rr[s] + 1) % WAYS;
      end
      m[s][vw] = '{1, tag_of(pc), tg, 2};
    end
  endtask

  task automatic m_edge();
    int s;
    if (rst || flush) begin
      m_busy = SETS;
    end else if (m_busy > 0) begin
      s = SETS - m_busy;
      for (int w = 0; w < WAYS; w++) m[s][w].v = 0;
      m_rr[s] = 0;
      m_busy--;
    end else if (cflow_valid) begin
      m_train(pc_e, cflow_taken, cflow_target);
    end
  endtask

  task automatic step_edge();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  task automatic chk(
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, got, exp);
    end
  endtask

  task automatic drive(
    input logic        r,
    input logic        f,
    input logic [31:0] pf,
    input logic        cv,
    input logic        ct,
    input logic [31:0] pe,
    input logic [31:0] tg);
    rst          = r;
    flush        = f;
    pc_f         = pf;
    cflow_valid  = cv;
    cflow_taken  = ct;
    pc_e         = pe;
    cflow_target = tg;
  endtask

  function automatic logic [31:0] rnd_pc();
    int unsigned v;
    v = ($urandom_range(0, 5) << 6) |
        ($urandom_range(0, 3) << 2) |
        $urandom_range(0, 3);
    return 32'(v);
  endfunction

  typedef struct {
    logic [31:0] pcf;
    bit          cv;
    bit          ct;
    logic [31:0] pce;
    logic [31:0] tgt;
    bit          hit;
    bit          tk;
    logic [31:0] ptg;
  } vec_t;

  vec_t vt [$];

  initial begin
    bit          h;
    bit          t;
    logic [31:0] g;

    vt.push_back('{32'h100, 1, 1, 32'h100, 32'h200, 0, 0, 32'h0});
    vt.push_back('{32'h100, 0, 0, 32'h0,   32'h0,   1, 1, 32'h200});
    vt.push_back('{32'h100, 1, 0, 32'h100, 32'h0,   1, 1, 32'h200});
    vt.push_back('{32'h100, 1, 0, 32'h100, 32'h0,   1, 0, 32'h200});
    vt.push_back('{32'h100, 1, 0, 32'h100, 32'h0,   1, 0, 32'h200});
    vt.push_back('{32'h100, 1, 1, 32'h100, 32'h300, 1, 0, 32'h200});
    vt.push_back('{32'h100, 1, 1, 32'h100, 32'h300, 1, 0, 32'h300});
    vt.push_back('{32'h100, 0, 0, 32'h0,   32'h0,   1, 1, 32'h300});
    vt.push_back('{32'h140, 1, 1, 32'h140, 32'h440, 0, 0, 32'h0});
    vt.push_back('{32'h140, 1, 1, 32'h180, 32'h480, 1, 1, 32'h440});
    vt.push_back('{32'h100, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0});
    vt.push_back('{32'h180, 0, 0, 32'h0,   32'h0,   1, 1, 32'h480});
    vt.push_back('{32'h140, 0, 0, 32'h0,   32'h0,   1, 1, 32'h440});
    vt.push_back('{32'h1C0, 1, 0, 32'h1C0, 32'h5C0, 0, 0, 32'h0});
    vt.push_back('{32'h180, 1, 1, 32'h1C0, 32'h4C0, 1, 1, 32'h480});
    vt.push_back('{32'h140, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0});
    vt.push_back('{32'h1C0, 0, 0, 32'h0,   32'h0,   1, 1, 32'h4C0});
    vt.push_back('{32'h180, 0, 0, 32'h0,   32'h0,   1, 1, 32'h480});
    vt.push_back('{32'h104, 0, 0, 32'h0,   32'h0,   0, 0, 32'h0});

    // Reset: exactly SETS busy cycles, all lookups miss.
    drive(1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    step_edge();
    drive(0, 0, 32'h0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < SETS; i++) begin
      pc_f = rnd_pc();
      @(negedge clk);
      chk($sformatf("rst_busy%0d", i), 32'(busy), 32'h1);
      chk($sformatf("rst_hit%0d", i), 32'(btb_hit), 32'h0);
      step_edge();
    end
    pc_f = 32'h100;
    @(negedge clk);
    chk("rst_busy_end", 32'(busy), 32'h0);
    chk("rst_hit_end", 32'(btb_hit), 32'h0);
    chk("rst_tgt_end", pred_target, 32'h0);
    step_edge();

    // Directed table.
    foreach (vt[i]) begin
      drive(0, 0, vt[i].pcf, vt[i].cv, vt[i].ct,
            vt[i].pce, vt[i].tgt);
      @(negedge clk);
      chk($sformatf("vec%0d_hit", i),
          32'(btb_hit), 32'(vt[i].hit));
      chk($sformatf("vec%0d_taken", i),
          32'(pred_taken), 32'(vt[i].tk));
      chk($sformatf("vec%0d_target", i),
          pred_target, vt[i].ptg);
      step_edge();
    end

    // Flush, then re-flush at sweep cycle 8.
    drive(0, 1, 32'h180, 0, 0, 32'h0, 32'h0);
    step_edge();
    flush = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("fl_busy%0d", k), 32'(busy), 32'h1);
      step_edge();
    end
    flush = 1;
    @(negedge clk);
    chk("fl_busy8", 32'(busy), 32'h1);
    step_edge();
    flush = 0;
    for (int k = 0; k < SETS; k++) begin
      cflow_valid  = (k == 5);
      cflow_taken  = 1;
      pc_e         = 32'h100;
      cflow_target = 32'h900;
      @(negedge clk);
      chk($sformatf("rfl_busy%0d", k), 32'(busy), 32'h1);
      chk($sformatf("rfl_hit%0d", k), 32'(btb_hit), 32'h0);
      step_edge();
    end
    drive(0, 0, 32'h100, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rfl_busy_end", 32'(busy), 32'h0);
    chk("rfl_drop_hit", 32'(btb_hit), 32'h0);
    step_edge();
    pc_f = 32'h180;
    @(negedge clk);
    chk("rfl_inval_hit", 32'(btb_hit), 32'h0);
    step_edge();

    // Random traffic against the model.
    for (int c = 0; c < NRND; c++) begin
      rst          = ($urandom_range(0, 499) == 0);
      flush        = ($urandom_range(0, 199) == 0);
      pc_e         = rnd_pc();
      pc_f         = ($urandom_range(0, 3) == 0) ?
                     pc_e : rnd_pc();
      cflow_valid  = 1'($urandom_range(0, 1));
      cflow_taken  = ($urandom_range(0, 9) < 6);
      cflow_target = 32'($urandom);
      @(negedge clk);
      m_lookup(pc_f, h, t, g);
      chk($sformatf("rnd%0d_busy", c),
          32'(busy), 32'(m_busy > 0));
      chk($sformatf("rnd%0d_hit", c),
          32'(btb_hit), 32'(h));
      chk($sformatf("rnd%0d_taken", c),
          32'(pred_taken), 32'(t));
      chk($sformatf("rnd%0d_target", c),
          pred_target, g);
      step_edge();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
